// File: rtl/core_lsu_bus_if.sv
// Data-bus bundle between the memory-stage load/store master and the memory port.
// Request side stays stable while M_REQ is high and M_GNT is low.
interface core_lsu_bus_if;
   // Valid/ready rule: the master raises M_REQ with M_WE/M_ADDR/M_WSTRB/M_WDATA and holds
   // them unchanged until a cycle with M_GNT=1. The request is accepted on that rising edge.
   // One M_RVALID pulse, in the grant cycle or later, then ends the transaction.
   logic        M_REQ;
   logic        M_WE;
   logic [31:0] M_ADDR;
   logic [3:0]  M_WSTRB;
   logic [31:0] M_WDATA;
   logic        M_GNT;
   logic        M_RVALID;
   logic [31:0] M_RDATA;

   modport master (
      output M_REQ, M_WE, M_ADDR, M_WSTRB, M_WDATA,
      input  M_GNT, M_RVALID, M_RDATA
   );

   modport slave (
      input  M_REQ, M_WE, M_ADDR, M_WSTRB, M_WDATA,
      output M_GNT, M_RVALID, M_RDATA
   );
endinterface

// File: rtl/core_lsu_bus.sv
// Memory-stage load/store bus master: runs one bus access per start pulse and returns
// BUSY/DONE/ERR plus lane-aligned, sign- or zero-extended load data.
module core_lsu_bus #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        CLK,
   input  logic        NRST,
   input  logic        ISLOAD_SS,
   input  logic        ISSTORE_SS,
   input  logic [31:0] ADDR,
   input  logic [3:0]  STRB,
   input  logic        ISLOADBS,
   input  logic        ISLOADHWS,
   input  logic [31:0] WDATA,
   input  logic        ACK,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR,
   output logic [31:0] LOAD_DATA,
   output logic [1:0]  DBG_STATE,
   core_lsu_bus_if.master m_bus
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_FIN} state_t;

   localparam logic [16:0] LP_LIMIT = 17'(TIMEOUT_CYCLES);

   state_t      r_state;
   logic        r_req;
   logic        r_busy;
   logic        r_done;
   logic        r_err;
   logic [31:0] r_load_data;
   logic        r_we;
   logic [31:0] r_addr;
   logic [1:0]  r_addr_lo;
   logic [3:0]  r_strb;
   logic        r_sbs;
   logic        r_shs;
   logic [31:0] r_wdata;
   logic [15:0] r_cnt;

   logic [2:0]  w_nlanes;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_ext;
   logic [16:0] w_cnt_nxt;
   logic        w_complete;

   assign w_nlanes = {2'b00, r_strb[0]} + {2'b00, r_strb[1]}
                   + {2'b00, r_strb[2]} + {2'b00, r_strb[3]};
   assign w_half   = (r_strb == 4'b0011) ? m_bus.M_RDATA[15:0] : m_bus.M_RDATA[31:16];
   assign w_cnt_nxt = {1'b0, r_cnt} + 17'd1;
   assign w_complete = m_bus.M_RVALID &
                       ((r_state == S_RESP) || ((r_state == S_REQ) && m_bus.M_GNT));

   always_comb begin
      w_byte = m_bus.M_RDATA[7:0];
      case (r_addr_lo)
         2'd1:    w_byte = m_bus.M_RDATA[15:8];
         2'd2:    w_byte = m_bus.M_RDATA[23:16];
         2'd3:    w_byte = m_bus.M_RDATA[31:24];
         default: w_byte = m_bus.M_RDATA[7:0];
      endcase
   end

   // Only the two naturally aligned halfword strobes are extended; odd pairs pass raw.
   always_comb begin
      w_load_ext = m_bus.M_RDATA;
      case (w_nlanes)
         3'd1: w_load_ext = {{24{r_sbs & w_byte[7]}}, w_byte};
         3'd2: begin
            if ((r_strb == 4'b0011) || (r_strb == 4'b1100))
               w_load_ext = {{16{r_shs & w_half[15]}}, w_half};
         end
         default: w_load_ext = m_bus.M_RDATA;
      endcase
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         r_state     <= S_IDLE;
         r_req       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_load_data <= 32'd0;
         r_we        <= 1'b0;
         r_addr      <= 32'd0;
         r_addr_lo   <= 2'd0;
         r_strb      <= 4'd0;
         r_sbs       <= 1'b0;
         r_shs       <= 1'b0;
         r_wdata     <= 32'd0;
         r_cnt       <= 16'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (ISLOAD_SS || ISSTORE_SS) begin
                  r_state   <= S_REQ;
                  r_req     <= 1'b1;
                  r_busy    <= 1'b1;
                  r_we      <= ~ISLOAD_SS;
                  r_addr    <= {ADDR[31:2], 2'b00};
                  r_addr_lo <= ADDR[1:0];
                  r_strb    <= STRB;
                  r_sbs     <= ISLOADBS;
                  r_shs     <= ISLOADHWS;
                  r_wdata   <= WDATA << {ADDR[1:0], 3'b000};
                  r_cnt     <= 16'd0;
               end
            end
            S_REQ, S_RESP: begin
               // A response on the limit cycle still counts as a clean completion.
               if (w_complete) begin
                  r_state     <= S_FIN;
                  r_req       <= 1'b0;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                  r_err       <= 1'b0;
                  r_load_data <= r_we ? 32'd0 : w_load_ext;
               end else if (w_cnt_nxt == LP_LIMIT) begin
                  r_state     <= S_FIN;
                  r_req       <= 1'b0;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                  r_err       <= 1'b1;
                  r_load_data <= 32'd0;
               end else begin
                  r_cnt <= w_cnt_nxt[15:0];
                  if ((r_state == S_REQ) && m_bus.M_GNT) begin
                     r_state <= S_RESP;
                     r_req   <= 1'b0;
                  end
               end
            end
            S_FIN: begin
               if (ACK) begin
                  r_state     <= S_IDLE;
                  r_done      <= 1'b0;
                  r_err       <= 1'b0;
                  r_load_data <= 32'd0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign BUSY          = r_busy;
   assign DONE          = r_done;
   assign ERR           = r_err;
   assign LOAD_DATA     = r_load_data;
   assign DBG_STATE     = r_state;
   assign m_bus.M_REQ   = r_req;
   assign m_bus.M_WE    = r_we;
   assign m_bus.M_ADDR  = r_addr;
   assign m_bus.M_WSTRB = r_strb;
   assign m_bus.M_WDATA = r_wdata;

endmodule

// File: doc/core_lsu_bus.md
Name: core_lsu_bus

Overview:
- Memory-stage load/store bus master.
- Consumes the single-cycle ISLOAD_SS/ISSTORE_SS pulses, effective address, byte strobe and signedness flags produced by the load/store control stage.
- Runs one data-bus transaction per pulse and returns BUSY/DONE to that control stage.
- Delivers aligned, sign/zero-extended load data to writeback.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in REQ+RESP before the access is aborted with ERR; legal range 1..65535.

Ports:
- CLK  in  1  clock, rising edge.
- NRST  in  1  reset; asynchronous, active-low.
- ISLOAD_SS  in  1  single-cycle load start.
- ISSTORE_SS  in  1  single-cycle store start.
- ADDR  in  32  effective byte address.
- STRB  in  4  byte-lane strobe, already positioned by ADDR[1:0].
- ISLOADBS  in  1  signed byte load.
- ISLOADHWS  in  1  signed halfword load.
- WDATA  in  32  unshifted store data (rs2).
- ACK  in  1  pipeline has consumed the result; clears DONE.
- BUSY  out  1  transaction in flight.
- DONE  out  1  result valid; held until ACK.
- ERR  out  1  timeout flag; valid while DONE=1.
- LOAD_DATA  out  32  extended load result; valid while DONE=1.
- M_REQ  out  1  bus request.
- M_WE  out  1  1 = write.
- M_ADDR  out  32  word-aligned address, {ADDR[31:2],2'b00}.
- M_WSTRB  out  4  write/read lane strobe.
- M_WDATA  out  32  lane-shifted store data.
- M_GNT  in  1  request accepted.
- M_RVALID  in  1  response (read data valid, or write complete).
- M_RDATA  in  32  read data.

Behaviour:
- Reset: async, NRST=0 forces state IDLE. All outputs and internal registers clear to 0 immediately, including M_REQ mid-transaction. No pending access survives reset.
- States: IDLE, REQ, RESP, FIN.
- IDLE:
  - ISLOAD_SS or ISSTORE_SS at a rising edge latches ADDR, STRB, sign flags and WDATA, then moves to REQ.
  - If both are high, load wins (M_WE=0).
  - Start pulses in any other state are ignored.
- M_WDATA = WDATA << (8*ADDR[1:0]), truncated to 32 bits. M_WSTRB = latched STRB, passed through unchanged (including 0110).
- REQ:
  - M_REQ=1, BUSY=1; all M_* outputs held stable until M_GNT.
  - M_GNT=1 and M_RVALID=0 -> RESP.
  - M_GNT=1 and M_RVALID=1 in the same cycle -> FIN.
- RESP:
  - M_REQ=0, BUSY=1.
  - M_RVALID=1 -> FIN.
  - M_RVALID outside REQ/RESP is ignored.
- Load data capture, registered on entry to FIN for loads:
  - Lane select by popcount(STRB):
    - 1 -> byte at lane ADDR[1:0].
    - 2 -> halfword: STRB=0011 uses [15:0], 1100 uses [31:16].
    - 4 -> full word.
  - Byte is sign-extended if ISLOADBS=1, else zero-extended. Halfword is sign-extended if ISLOADHWS=1, else zero-extended.
  - Other strobe patterns: LOAD_DATA = M_RDATA unmodified.
  - Stores: LOAD_DATA = 0.
- Timeout:
  - Cycle counter clears on leaving IDLE and increments each cycle in REQ or RESP.
  - When the counter reaches TIMEOUT_CYCLES without completion: go to FIN with ERR=1, LOAD_DATA=0, M_REQ dropped.
  - Completion in the same cycle as the limit wins (ERR=0).
- FIN:
  - DONE=1, BUSY=0; LOAD_DATA and ERR held.
  - ACK=1 -> IDLE next cycle; DONE, ERR and LOAD_DATA clear to 0.
  - A start pulse in the ACK cycle is ignored. The upstream stage gates starts with !BUSY & !DONE, so the earliest new start is the first IDLE cycle.
- BUSY and DONE are never high together; both are registered state decodes.
- Latency with zero-wait bus (M_GNT in first REQ cycle, M_RVALID next): start edge -> DONE high 3 edges later.

Test Plan:
- LB at ADDR=0x1003, STRB=1000, ISLOADBS=1, M_RDATA=0x80AABBCC, immediate grant, response next cycle -> M_ADDR=0x1000, M_WE=0; DONE after 3 edges with LOAD_DATA=0xFFFFFF80, ERR=0; ACK returns to IDLE.
- LHU at ADDR=0x2002, STRB=1100, both sign flags 0, M_RDATA=0xF00D1234 -> LOAD_DATA=0x0000F00D. Repeat with ISLOADHWS=1 -> 0xFFFFF00D.
- SB at ADDR=0x3001, STRB=0010, WDATA=0x000000A5 -> M_WE=1, M_WSTRB=0010, M_WDATA=0x0000A500. DONE after M_RVALID, LOAD_DATA=0.
- Stall M_GNT low 5 cycles -> M_REQ and all M_* outputs stable for 5 cycles; BUSY=1 throughout; ISLOAD_SS pulse mid-stall is ignored (no second request).
- TIMEOUT_CYCLES=8, M_GNT never asserted -> DONE=1, ERR=1, LOAD_DATA=0 exactly 8 cycles after REQ entry; M_REQ low in FIN.
- Assert NRST=0 asynchronously during RESP -> M_REQ, BUSY and DONE drop to 0 before the next clock edge. After release, a new LW with grant and response both in the first REQ cycle -> DONE after 2 edges.
